// File: rtl/fsb_pkg.sv
// Shared types, widths and default timing for the FSB cycle terminator.
package fsb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    TERM   = 2'd2
  } fsbState_t;

  localparam int unsigned DEF_NSRC       = 4;
  localparam int unsigned DEF_TOA_CYC    = 32;
  localparam int unsigned DEF_TOB_CYC    = 256;
  localparam int unsigned DEF_REF_PERIOD = 234;
  localparam int unsigned DEF_REF_URGENT = 64;

  // Bits needed to hold values 0..n.
  function automatic int unsigned cntw(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fsb_refresh_timer.sv
// Free-running DRAM refresh request timer with urgency escalation.
module fsb_refresh_timer
  import fsb_pkg::*;
#(
  parameter int unsigned REF_PERIOD = DEF_REF_PERIOD,
  parameter int unsigned REF_URGENT = DEF_REF_URGENT
) (
  input  logic CLK_FSB,
  input  logic nRES,
  input  logic RefAck,
  output logic RefReq,
  output logic RefUrgent
);

  localparam int unsigned PW = cntw(REF_PERIOD - 1);
  localparam int unsigned UW = cntw(REF_URGENT);

  logic [PW-1:0] perCnt;
  logic [UW-1:0] urgCnt;
  logic          expire;

  assign expire = (perCnt == '0);

  // Period down-counter, request latch and pending-time urgency counter.
  always_ff @(posedge CLK_FSB or negedge nRES) begin
    if (!nRES) begin
      perCnt    <= PW'(REF_PERIOD - 1);
      urgCnt    <= '0;
      RefReq    <= 1'b0;
      RefUrgent <= 1'b0;
    end else begin
      perCnt <= expire ? PW'(REF_PERIOD - 1) : perCnt - 1'b1;
      if (RefAck) begin
        // A fresh expiry on the ack edge starts a new request with zero age.
        RefReq    <= expire;
        RefUrgent <= 1'b0;
        urgCnt    <= '0;
      end else begin
        if (expire) begin
          RefReq <= 1'b1;
        end
        if (RefReq && !RefUrgent) begin
          urgCnt <= urgCnt + 1'b1;
          if (urgCnt == UW'(REF_URGENT - 1)) begin
            RefUrgent <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fsb_term_ctrl.sv
// FSB cycle terminator: source ready/error merge, timeouts, DTACK/VPA/BERR.
module fsb_term_ctrl
  import fsb_pkg::*;
#(
  parameter int unsigned NSRC       = DEF_NSRC,
  parameter int unsigned TOA_CYC    = DEF_TOA_CYC,
  parameter int unsigned TOB_CYC    = DEF_TOB_CYC,
  parameter int unsigned REF_PERIOD = DEF_REF_PERIOD,
  parameter int unsigned REF_URGENT = DEF_REF_URGENT
) (
  input  logic            CLK_FSB,
  input  logic            nRES,
  input  logic            nAS_FSB,
  input  logic [NSRC-1:0] SrcSel,
  input  logic [NSRC-1:0] SrcReady,
  input  logic [NSRC-1:0] SrcBerr,
  input  logic [NSRC-1:0] SrcToEn,
  input  logic            IACS,
  input  logic            RefAck,
  output logic            nDTACK_FSB,
  output logic            nVPA_FSB,
  output logic            nBERR_FSB,
  output logic            ASActive,
  output logic            ASInactive,
  output logic            RefReq,
  output logic            RefUrgent,
  output logic            TimeoutA,
  output logic            TimeoutB
);

  localparam int unsigned CW = cntw(TOB_CYC);

  fsbState_t     state, stateNext;
  logic [CW-1:0] cycCnt, cycCntNext;
  logic          nDtackNext, nVpaNext, nBerrNext;
  logic          asPrev;
  logic          toA, toB, ready, srcBerr, hold, dtackCond, berrCond;

  fsb_refresh_timer #(
    .REF_PERIOD(REF_PERIOD),
    .REF_URGENT(REF_URGENT)
  ) uRefresh (
    .CLK_FSB  (CLK_FSB),
    .nRES     (nRES),
    .RefAck   (RefAck),
    .RefReq   (RefReq),
    .RefUrgent(RefUrgent)
  );

  // Termination conditions for the current ACTIVE cycle.
  assign toA       = (state == ACTIVE) && (cycCnt >= CW'(TOA_CYC));
  assign toB       = (state == ACTIVE) && (cycCnt >= CW'(TOB_CYC));
  assign ready     = (|SrcSel) && (&(~SrcSel | SrcReady | (SrcToEn & {NSRC{toA}})));
  assign srcBerr   = |(SrcSel & SrcBerr);
  assign hold      = RefUrgent && !RefAck;
  assign dtackCond = ready && !hold;
  assign berrCond  = srcBerr || (toB && !IACS && !dtackCond);

  // Next-state, cycle counter and termination selection.
  always_comb begin
    stateNext  = state;
    cycCntNext = cycCnt;
    nDtackNext = 1'b1;
    nVpaNext   = 1'b1;
    nBerrNext  = 1'b1;
    case (state)
      IDLE: begin
        cycCntNext = '0;
        if (!nAS_FSB) begin
          stateNext = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!hold && (cycCnt < CW'(TOB_CYC))) begin
          cycCntNext = cycCnt + 1'b1;
        end
        if (nAS_FSB) begin
          stateNext = IDLE;
        end else if (berrCond) begin
          nBerrNext = 1'b0;
          stateNext = TERM;
        end else if (IACS) begin
          nVpaNext  = 1'b0;
          stateNext = TERM;
        end else if (dtackCond) begin
          nDtackNext = 1'b0;
          stateNext  = TERM;
        end
      end
      TERM: begin
        if (nAS_FSB) begin
          stateNext = IDLE;
        end else begin
          nDtackNext = nDTACK_FSB;
          nVpaNext   = nVPA_FSB;
          nBerrNext  = nBERR_FSB;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLK_FSB or negedge nRES) begin
    if (!nRES) begin
      state      <= IDLE;
      cycCnt     <= '0;
      nDTACK_FSB <= 1'b1;
      nVPA_FSB   <= 1'b1;
      nBERR_FSB  <= 1'b1;
      ASActive   <= 1'b0;
      asPrev     <= 1'b1;
      ASInactive <= 1'b1;
      TimeoutA   <= 1'b0;
      TimeoutB   <= 1'b0;
    end else begin
      state      <= stateNext;
      cycCnt     <= cycCntNext;
      nDTACK_FSB <= nDtackNext;
      nVPA_FSB   <= nVpaNext;
      nBERR_FSB  <= nBerrNext;
      ASActive   <= ~nAS_FSB;
      asPrev     <= nAS_FSB;
      ASInactive <= asPrev & nAS_FSB;
      TimeoutA   <= (stateNext == ACTIVE) && (cycCntNext >= CW'(TOA_CYC));
      TimeoutB   <= (stateNext == ACTIVE) && (cycCntNext >= CW'(TOB_CYC));
    end
  end

endmodule

// File: tb/tb_fsb_term_ctrl.sv
// Self-checking bench for fsb_term_ctrl: vector table, corner sequences, random vs model.
module tb_fsb_term_ctrl;

  localparam int unsigned NSRC = 4;
  localparam int unsigned TOA  = 32;
  localparam int unsigned TOB  = 256;
  localparam int unsigned RP   = 234;
  localparam int unsigned RU   = 64;

  logic CLK_FSB = 1'b0;
  logic nRES, nAS_FSB, IACS, RefAck;
  logic [NSRC-1:0] SrcSel, SrcReady, SrcBerr, SrcToEn;
  logic nDTACK_FSB, nVPA_FSB, nBERR_FSB, ASActive, ASInactive;
  logic RefReq, RefUrgent, TimeoutA, TimeoutB;

  int nChecks = 0;
  int nFails  = 0;

  fsb_term_ctrl #(
    .NSRC(NSRC), .TOA_CYC(TOA), .TOB_CYC(TOB), .REF_PERIOD(RP), .REF_URGENT(RU)
  ) dut (
    .CLK_FSB(CLK_FSB), .nRES(nRES), .nAS_FSB(nAS_FSB), .SrcSel(SrcSel),
    .SrcReady(SrcReady), .SrcBerr(SrcBerr), .SrcToEn(SrcToEn), .IACS(IACS),
    .RefAck(RefAck), .nDTACK_FSB(nDTACK_FSB), .nVPA_FSB(nVPA_FSB),
    .nBERR_FSB(nBERR_FSB), .ASActive(ASActive), .ASInactive(ASInactive),
    .RefReq(RefReq), .RefUrgent(RefUrgent), .TimeoutA(TimeoutA), .TimeoutB(TimeoutB)
  );

  always #5 CLK_FSB = ~CLK_FSB;

  // Behavioural model: bus-cycle bookkeeping and edge-number based refresh.
  bit          mInCyc, mDone, mLastAs, mReq, mUrg, eAsAct, eAsInact, eToA, eToB;
  logic [2:0]  eTerm;
  int unsigned mWait, mPend, mEdge;

  function automatic logic [8:0] dutOuts();
    return {nDTACK_FSB, nVPA_FSB, nBERR_FSB, ASActive, ASInactive,
            RefReq, RefUrgent, TimeoutA, TimeoutB};
  endfunction

  function automatic logic [8:0] expOuts();
    return {eTerm, eAsAct, eAsInact, mReq, mUrg, eToA, eToB};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s @%0t: outs got %b want %b (nD nV nB act inact req urg toA toB)",
               name, $time, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    mInCyc = 0; mDone = 0; mLastAs = 1; mReq = 0; mUrg = 0;
    eAsAct = 0; eAsInact = 1; eToA = 0; eToB = 0; eTerm = 3'b111;
    mWait = 0; mPend = 0; mEdge = 0;
  endtask

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic modelEdge();
    bit hold, rdy, srcB, dt, be, expire;
    hold = mUrg && !RefAck;
    if (!mInCyc) begin
      if (!nAS_FSB) begin
        mInCyc = 1; mDone = 0; mWait = 0; eTerm = 3'b111;
      end
    end else if (!mDone) begin
      if (nAS_FSB) begin
        mInCyc = 0;
      end else begin
        rdy  = (SrcSel != '0);
        srcB = 0;
        for (int i = 0; i < NSRC; i++) begin
          if (SrcSel[i] && !SrcReady[i] && !(SrcToEn[i] && mWait >= TOA)) rdy = 0;
          if (SrcSel[i] && SrcBerr[i]) srcB = 1;
        end
        dt = rdy && !hold;
        be = srcB || (mWait >= TOB && !IACS && !dt);
        if (be)        begin mDone = 1; eTerm = 3'b110; end
        else if (IACS) begin mDone = 1; eTerm = 3'b101; end
        else if (dt)   begin mDone = 1; eTerm = 3'b011; end
        if (!hold && mWait < TOB) mWait++;
      end
    end else if (nAS_FSB) begin
      mInCyc = 0;
    end
    if (!mInCyc) eTerm = 3'b111;
    eToA = mInCyc && !mDone && mWait >= TOA;
    eToB = mInCyc && !mDone && mWait >= TOB;
    eAsAct   = !nAS_FSB;
    eAsInact = mLastAs && nAS_FSB;
    mLastAs  = nAS_FSB;
    mEdge++;
    expire = (mEdge % RP == 0);
    if (RefAck) begin
      mReq = expire; mUrg = 0; mPend = 0;
    end else begin
      if (mReq && !mUrg) begin
        mPend++;
        if (mPend >= RU) mUrg = 1;
      end
      if (expire) mReq = 1;
    end
  endtask

  task automatic step(input string name);
    modelEdge();
    @(posedge CLK_FSB); #1;
    check(name, dutOuts(), expOuts());
  endtask

  task automatic idleInputs();
    nAS_FSB = 1; SrcSel = '0; SrcReady = '0; SrcBerr = '0; SrcToEn = '0;
    IACS = 0; RefAck = 0;
  endtask

  task automatic doReset();
    nRES = 0;
    idleInputs();
    modelReset();
    @(posedge CLK_FSB); #1;
    check("reset_state", dutOuts(), 9'b111_01_0000);
    nRES = 1;
  endtask

  // Step until any termination asserts; edges counts from the nAS-low sampling edge.
  task automatic runUntilTerm(input int limit, output int edges, output logic [2:0] term);
    edges = -1;
    term  = 3'b111;
    for (int e = 0; e <= limit; e++) begin
      step("seq_cycle");
      if ({nDTACK_FSB, nVPA_FSB, nBERR_FSB} != 3'b111) begin
        edges = e;
        term  = {nDTACK_FSB, nVPA_FSB, nBERR_FSB};
        break;
      end
    end
  endtask

  typedef struct {
    logic       nAs;
    logic [3:0] sel;
    logic [3:0] rdy;
    logic [3:0] berr;
    logic       iacs;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [22];

  initial begin
    int          edges, reqEdge, urgEdge;
    logic [2:0]  term;
    int unsigned r;

    // {nAs, sel, rdy, berr, iacs, {nD nV nB act inact req urg toA toB}}
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 9'b111_01_0000};
    tbl[1]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 9'b111_10_0000};
    tbl[2]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 9'b011_10_0000};
    tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 9'b011_10_0000};
    tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 9'b111_00_0000};
    tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 9'b111_01_0000};
    tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 9'b111_10_0000};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 9'b101_10_0000};
    tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 9'b111_00_0000};
    tbl[9]  = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b0, 9'b111_10_0000};
    tbl[10] = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b0, 9'b110_10_0000};
    tbl[11] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 9'b111_00_0000};
    tbl[12] = '{1'b0, 4'b0011, 4'b0001, 4'b0000, 1'b0, 9'b111_10_0000};
    tbl[13] = '{1'b0, 4'b0011, 4'b0001, 4'b0000, 1'b0, 9'b111_10_0000};
    tbl[14] = '{1'b0, 4'b0011, 4'b0011, 4'b0000, 1'b0, 9'b011_10_0000};
    tbl[15] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 9'b111_00_0000};
    tbl[16] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 9'b111_10_0000};
    tbl[17] = '{1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 9'b111_00_0000};
    tbl[18] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 9'b111_01_0000};
    tbl[19] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1, 9'b111_10_0000};
    tbl[20] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1, 9'b110_10_0000};
    tbl[21] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 9'b111_00_0000};

    // Vector table: basic DTACK, VPA, BERR, multi-select, abort and priority.
    doReset();
    for (int i = 0; i < 22; i++) begin
      nAS_FSB = tbl[i].nAs; SrcSel = tbl[i].sel; SrcReady = tbl[i].rdy;
      SrcBerr = tbl[i].berr; IACS = tbl[i].iacs;
      @(posedge CLK_FSB); #1;
      check($sformatf("table_%0d", i), dutOuts(), tbl[i].exp);
    end

    // Timeout A substitutes for a stuck source's ready.
    doReset();
    step("toa_idle");
    nAS_FSB = 0; SrcSel = 4'b0100; SrcToEn = 4'b0100;
    runUntilTerm(40, edges, term);
    checkInt("toa_latency", edges, int'(TOA) + 1);
    checkInt("toa_term", int'(term), 3);
    idleInputs();
    step("toa_end"); step("toa_end");

    // Unmapped cycle ends with timeout B bus error.
    doReset();
    step("tob_idle");
    nAS_FSB = 0;
    runUntilTerm(270, edges, term);
    checkInt("tob_latency", edges, int'(TOB) + 1);
    checkInt("tob_term", int'(term), 6);
    idleInputs();
    step("tob_end"); step("tob_end");

    // Refresh request, urgency and DTACK withholding until RefAck.
    doReset();
    reqEdge = -1; urgEdge = -1;
    for (int n = 1; n <= 400; n++) begin
      step("ref_wait");
      if (RefReq && reqEdge < 0) reqEdge = n;
      if (RefUrgent) begin urgEdge = n; break; end
    end
    checkInt("ref_req_edge", reqEdge, int'(RP));
    checkInt("ref_urgent_edge", urgEdge, int'(RP + RU));
    nAS_FSB = 0; SrcSel = 4'b0001; SrcReady = 4'b0001;
    for (int n = 0; n < 5; n++) step("ref_hold");
    checkInt("ref_dtack_withheld", int'(nDTACK_FSB), 1);
    RefAck = 1;
    step("ref_ack");
    RefAck = 0;
    checkInt("ref_dtack_after_ack", int'(nDTACK_FSB), 0);
    idleInputs();
    step("ref_end"); step("ref_end");

    // Asynchronous reset in the middle of an asserted DTACK.
    doReset();
    step("rst_idle");
    nAS_FSB = 0; SrcSel = 4'b0001; SrcReady = 4'b0001;
    step("rst_start"); step("rst_dtack");
    checkInt("rst_dtack_low", int'(nDTACK_FSB), 0);
    #2 nRES = 0;
    #1 check("rst_async", dutOuts(), 9'b111_01_0000);
    modelReset();
    @(posedge CLK_FSB); #1;
    nRES = 1;
    idleInputs();
    step("rst_resume_idle");
    nAS_FSB = 0; SrcSel = 4'b0001; SrcReady = 4'b0001;
    runUntilTerm(5, edges, term);
    checkInt("rst_resume_latency", edges, 1);
    checkInt("rst_resume_term", int'(term), 3);
    idleInputs();
    step("rst_resume_end");

    // Random cycles against the model.
    doReset();
    for (int n = 0; n < 4000; n++) begin
      step("random");
      if (nAS_FSB) begin
        if ($urandom_range(0, 2) == 0) begin
          nAS_FSB = 0;
          r = $urandom_range(0, 5);
          if (r == 0)      SrcSel = '0;
          else if (r <= 4) SrcSel = 4'(1 << (r - 1));
          else             SrcSel = 4'($urandom);
          IACS    = ($urandom_range(0, 9) == 0);
          SrcToEn = 4'($urandom);
        end
      end else if (mDone ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0)) begin
        nAS_FSB = 1;
      end
      SrcReady = 4'($urandom) & 4'($urandom);
      SrcBerr  = ($urandom_range(0, 19) == 0) ? 4'($urandom) : '0;
      RefAck   = (mReq && $urandom_range(0, 79) == 0) ||
                 (((mEdge + 1) % RP == 0) && $urandom_range(0, 1) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
